ahb_mem_slave: RTL

//  AHB-Lite slave responder: the far end of the master/slave bus interface pair.

---
 rtl/ahb_mem_slave.sv | 72 +++++++
 1 files changed

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite word memory slave with programmable wait states and two-cycle ERROR; in hclk/hreset/hsel/haddr/htrans/hwrite/hsize/hburst/hwdata/hready, out hreadyout/hresp/hrdata
module ahb_mem_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);
  localparam int NB = DATA_W / 8;
  localparam int LG = $clog2(NB);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, DATA = 3'd2, ERR1 = 3'd3, ERR2 = 3'd4;
  logic [2:0]        state, nxt;
  logic [3:0]        wcnt;
  logic [IW-1:0]     a_idx;
  logic [LG-1:0]     a_off;
  logic [2:0]        a_size;
  logic              a_write;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] mask;
  logic [NB-1:0]     be;
  logic              start, err;
  logic              unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};
  assign start = (state == IDLE || state == DATA || state == ERR2) && hsel && hready && htrans[1];
  always_comb begin
    mask = (ADDR_W'(1) << hsize) - ADDR_W'(1);
    err  = (hsize > 3'(LG)) || (|(haddr & mask)) || ((haddr >> LG) >= ADDR_W'(MEM_DEPTH));
    nxt  = start ? (err ? ERR1 : (WAIT_STATES > 0 ? WAIT : DATA)) :
           state == WAIT ? (wcnt == 4'(WAIT_STATES - 1) ? DATA : WAIT) :
           state == ERR1 ? ERR2 : IDLE;
    be   = NB'((16'(1) << (16'(1) << a_size)) - 16'(1)) << a_off;
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= nxt;
      wcnt  <= start ? '0 : (state == WAIT ? wcnt + 4'd1 : wcnt);
    end
  end
  always_ff @(posedge hclk) begin
    if (!hreset && start) begin
      a_idx   <= haddr[LG +: IW];
      a_off   <= haddr[LG-1:0];
      a_size  <= hsize;
      a_write <= hwrite;
    end
  end
  always_ff @(posedge hclk) begin
    if (!hreset && state == DATA && a_write)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[a_idx][8*i +: 8] <= hwdata[8*i +: 8];
  end
  assign hreadyout = !(state == WAIT || state == ERR1);
  assign hresp     = state == ERR1 || state == ERR2;
  assign hrdata    = (state == DATA && !a_write) ? mem[a_idx] : '0;
endmodule
